// File: rtl/zbuf_pkg.sv
// zbuf_pkg: shared constants and helpers for the z-buffer address generator.
// The per-instance widths (pixel x/y, pixel index) depend on the screen
// parameters of each instance, so they are derived in the top level with
// zbuf_clog2 rather than fixed here.
package zbuf_pkg;

  // Side of one square memory tile in the tiled layout, as a power of two (8x8).
  localparam int TILE_LOG2 = 3;

  // Ceiling log2 usable in constant expressions; zbuf_clog2(1) = 0.
  function automatic int zbuf_clog2(input int value);
    int res;
    int rem;
    res = 0;
    rem = value - 1;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/zbuf_pipe_stage.sv
// zbuf_pipe_stage: one elastic valid/ready register slice.
// The slice loads whenever it is empty or its current contents leave this
// cycle, so an empty slice never blocks the one upstream of it. Data is
// cleared on reset so a flushed pipeline presents all-zero outputs.
module zbuf_pipe_stage
  import zbuf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  assign up_ready = !valid_reg || dn_ready;
  assign dn_valid = valid_reg;
  assign dn_data  = data_reg;

  // Capture upstream data when there is room; hold steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (up_ready) begin
      valid_reg <= up_valid;
      if (up_valid) begin
        data_reg <= up_data;
      end
    end
  end

endmodule

// File: rtl/zbuf_addr_gen.sv
// zbuf_addr_gen: normalised (x,y) fragment coordinate -> frame buffer byte
// address. Three elastic stages: S1 scales Q1.(COORD_W-1) coordinates to
// pixel units, S2 clamps to the screen and linearises, S3 adds the base
// address. A sideband tag travels alongside unchanged.
// Build option: define ZBUF_TILED_EN to use an 8x8 tiled pixel layout in S2
// instead of the default row-linear layout.
module zbuf_addr_gen
  import zbuf_pkg::*;
#(
  parameter int              SCREEN_W  = 640,
  parameter int              SCREEN_H  = 480,
  parameter int              COORD_W   = 16,
  parameter int              BPP_LOG2  = 1,
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int              TAG_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] in_x,
  input  logic [COORD_W-1:0] in_y,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic [TAG_W-1:0]   out_tag,
  output logic               out_oob
);

  // Clamped pixel coordinate widths and the pixel index width.
  localparam int PX_W  = zbuf_clog2(SCREEN_W);
  localparam int PY_W  = zbuf_clog2(SCREEN_H);
  localparam int PIX_W = zbuf_clog2(SCREEN_W * SCREEN_H);
  // Inputs reach almost 2.0, so the scaled value needs one extra bit to
  // detect overshoot before clamping.
  localparam int RAW_X_W  = PX_W + 1;
  localparam int RAW_Y_W  = PY_W + 1;
  // Full-width products: no bits dropped before the floor shift.
  localparam int PROD_X_W = COORD_W + PX_W;
  localparam int PROD_Y_W = COORD_W + PY_W;

  typedef struct packed {
    logic [RAW_X_W-1:0] px_raw;
    logic [RAW_Y_W-1:0] py_raw;
    logic [TAG_W-1:0]   tag;
  } s1_t;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             oob;
    logic [TAG_W-1:0] tag;
  } s2_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              oob;
    logic [TAG_W-1:0]  tag;
  } s3_t;

  s1_t s1_next, s1_q;
  s2_t s2_next, s2_q;
  s3_t s3_next, s3_q;

  logic s1_valid, s2_valid, s3_valid;
  logic s1_ready, s2_ready, s3_ready;

  logic [PROD_X_W-1:0] prod_x;
  logic [PROD_Y_W-1:0] prod_y;
  logic [PX_W-1:0]     px;
  logic [PY_W-1:0]     py;
  logic [PIX_W-1:0]    tile_idx;

  // S1: scale normalised coordinates to pixel units (floor).
  always_comb begin
    prod_x         = PROD_X_W'(in_x) * PROD_X_W'(SCREEN_W - 1);
    prod_y         = PROD_Y_W'(in_y) * PROD_Y_W'(SCREEN_H - 1);
    s1_next.px_raw = RAW_X_W'(prod_x >> (COORD_W - 1));
    s1_next.py_raw = RAW_Y_W'(prod_y >> (COORD_W - 1));
    s1_next.tag    = in_tag;
  end

  // S2: clamp to the last pixel, flag overshoot, and form the pixel index.
  always_comb begin
    px = (s1_q.px_raw > RAW_X_W'(SCREEN_W - 1)) ? PX_W'(SCREEN_W - 1) : s1_q.px_raw[PX_W-1:0];
    py = (s1_q.py_raw > RAW_Y_W'(SCREEN_H - 1)) ? PY_W'(SCREEN_H - 1) : s1_q.py_raw[PY_W-1:0];
    s2_next.oob = (s1_q.px_raw > RAW_X_W'(SCREEN_W - 1)) ||
                  (s1_q.py_raw > RAW_Y_W'(SCREEN_H - 1));
    s2_next.tag = s1_q.tag;
`ifdef ZBUF_TILED_EN
    // Tile number first, then the 8x8 offset inside the tile.
    tile_idx    = PIX_W'(py >> TILE_LOG2) * PIX_W'(SCREEN_W >> TILE_LOG2) +
                  PIX_W'(px >> TILE_LOG2);
    s2_next.pix = (tile_idx << (2 * TILE_LOG2)) +
                  PIX_W'({py[TILE_LOG2-1:0], px[TILE_LOG2-1:0]});
`else
    tile_idx    = '0;
    s2_next.pix = PIX_W'(py) * PIX_W'(SCREEN_W) + PIX_W'(px);
`endif
  end

  // S3: scale pixel index to bytes and offset by the buffer base.
  always_comb begin
    s3_next.addr = BASE_ADDR + (ADDR_W'(s2_q.pix) << BPP_LOG2);
    s3_next.oob  = s2_q.oob;
    s3_next.tag  = s2_q.tag;
  end

  zbuf_pipe_stage #(.WIDTH($bits(s1_t))) u_s1 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (in_valid),
    .up_ready (s1_ready),
    .up_data  (s1_next),
    .dn_valid (s1_valid),
    .dn_ready (s2_ready),
    .dn_data  (s1_q)
  );

  zbuf_pipe_stage #(.WIDTH($bits(s2_t))) u_s2 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s1_valid),
    .up_ready (s2_ready),
    .up_data  (s2_next),
    .dn_valid (s2_valid),
    .dn_ready (s3_ready),
    .dn_data  (s2_q)
  );

  zbuf_pipe_stage #(.WIDTH($bits(s3_t))) u_s3 (
    .clk      (clk),
    .rst      (rst),
    .up_valid (s2_valid),
    .up_ready (s3_ready),
    .up_data  (s3_next),
    .dn_valid (s3_valid),
    .dn_ready (out_ready),
    .dn_data  (s3_q)
  );

  // Nothing is accepted while reset is held.
  assign in_ready  = !rst && s1_ready;
  assign out_valid = s3_valid;
  assign out_addr  = s3_q.addr;
  assign out_tag   = s3_q.tag;
  assign out_oob   = s3_q.oob;

endmodule

// File: tb/tb_zbuf_addr_gen.sv
// tb_zbuf_addr_gen: directed vector bench for zbuf_addr_gen (default
// parameters). Expected addresses are hand-computed for both the row-linear
// layout and the ZBUF_TILED_EN tiled layout.
module tb_zbuf_addr_gen;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [15:0] out_tag;
  logic        out_oob;

  zbuf_addr_gen dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_tag   (out_tag),
    .out_oob   (out_oob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ZBUF_TILED_EN
  localparam bit TILED = 1'b1;
`else
  localparam bit TILED = 1'b0;
`endif

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] tag;
    logic [31:0] addr;
    logic        oob;
  } vec_t;

  vec_t vecs[10];
  int   n_vec;
  int   n_miss;

  function automatic logic [31:0] pick(input logic [31:0] lin, input logic [31:0] til);
    return TILED ? til : lin;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One isolated fragment: checks acceptance, 3-cycle latency and results.
  task automatic run_vec(input int i);
    @(negedge clk);
    in_valid  = 1'b1;
    in_x      = vecs[i].x;
    in_y      = vecs[i].y;
    in_tag    = vecs[i].tag;
    out_ready = 1'b1;
    #1;
    check("vec_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("vec_lat1_valid", out_valid, 0);
    @(negedge clk);
    check("vec_lat2_valid", out_valid, 0);
    @(negedge clk);
    check("vec_lat3_valid", out_valid, 1);
    check("vec_addr", out_addr, vecs[i].addr);
    check("vec_tag", out_tag, vecs[i].tag);
    check("vec_oob", out_oob, vecs[i].oob);
    $display("vec %0d x=0x%04h y=0x%04h -> addr=0x%0h tag=0x%04h oob=%0b",
             i, vecs[i].x, vecs[i].y, out_addr, out_tag, out_oob);
  endtask

  initial begin
    int acc;
    int emi;
    int cyc;
    bit stalled_prev;
    logic [31:0] prev_addr;
    logic [15:0] prev_tag;
    logic        prev_oob;

    n_vec  = 0;
    n_miss = 0;

    //         x        y        tag      linear addr / tiled addr               oob
    vecs[0] = '{16'h8000, 16'h8000, 16'hA001, pick(32'h95FFE, 32'h95FFE), 1'b0};
    vecs[1] = '{16'h4000, 16'h4000, 16'hBEEF, pick(32'h4AD7E, 32'h49BFE), 1'b0};
    vecs[2] = '{16'hC000, 16'h0000, 16'hA003, pick(32'h004FE, 32'h0278E), 1'b1};
    vecs[3] = '{16'h019B, 16'h0045, 16'hA004, pick(32'h00510, 32'h00090), 1'b0};
    vecs[4] = '{16'h0000, 16'h0000, 16'hA005, pick(32'h00000, 32'h00000), 1'b0};
    vecs[5] = '{16'h0000, 16'h8000, 16'hA006, pick(32'h95B00, 32'h93870), 1'b0};
    vecs[6] = '{16'h8000, 16'h0000, 16'hA007, pick(32'h004FE, 32'h0278E), 1'b0};
    vecs[7] = '{16'h0000, 16'hFFFF, 16'hA008, pick(32'h95B00, 32'h93870), 1'b1};
    vecs[8] = '{16'h2000, 16'h2000, 16'hA009, pick(32'h2543E, 32'h239FE), 1'b0};
    vecs[9] = '{16'h0100, 16'h0200, 16'hA00A, pick(32'h02308, 32'h00078), 1'b0};

    // Reset state.
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_addr", out_addr, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_oob", out_oob, 0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);
    $display("reset released");

    // Isolated vectors.
    for (int i = 0; i < 10; i++) begin
      run_vec(i);
    end

    // Back-to-back stream with out_ready low on cycles 2..7.
    @(negedge clk);
    acc          = 0;
    emi          = 0;
    cyc          = 0;
    stalled_prev = 1'b0;
    prev_addr    = '0;
    prev_tag     = '0;
    prev_oob     = 1'b0;
    while (emi < 10 && cyc < 100) begin
      out_ready = !(cyc >= 2 && cyc <= 7);
      in_valid  = (acc < 10);
      if (acc < 10) begin
        in_x   = vecs[acc].x;
        in_y   = vecs[acc].y;
        in_tag = vecs[acc].tag;
      end
      #1;
      if (cyc == 4) begin
        check("stall_in_ready", in_ready, 0);
        check("stall_accepted", acc, 3);
      end
      if (stalled_prev) begin
        check("stall_hold_valid", out_valid, 1);
        check("stall_hold_addr", out_addr, prev_addr);
        check("stall_hold_tag", out_tag, prev_tag);
        check("stall_hold_oob", out_oob, prev_oob);
      end
      if (out_valid && out_ready) begin
        check("stream_addr", out_addr, vecs[emi].addr);
        check("stream_tag", out_tag, vecs[emi].tag);
        check("stream_oob", out_oob, vecs[emi].oob);
        $display("stream out %0d cyc=%0d addr=0x%0h tag=0x%04h oob=%0b",
                 emi, cyc, out_addr, out_tag, out_oob);
        emi = emi + 1;
      end
      stalled_prev = out_valid && !out_ready;
      prev_addr    = out_addr;
      prev_tag     = out_tag;
      prev_oob     = out_oob;
      if (in_valid && in_ready) begin
        acc = acc + 1;
      end
      @(negedge clk);
      cyc = cyc + 1;
    end
    in_valid = 1'b0;
    check("stream_emitted", emi, 10);
    check("stream_accepted", acc, 10);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stream_no_extra", out_valid, 0);
      @(negedge clk);
    end

    // Reset with two fragments in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = vecs[1].x;
    in_y      = vecs[1].y;
    in_tag    = vecs[1].tag;
    @(negedge clk);
    in_x      = vecs[2].x;
    in_y      = vecs[2].y;
    in_tag    = vecs[2].tag;
    @(negedge clk);
    in_valid  = 1'b0;
    @(negedge clk);
    #1;
    check("flush_pre_valid", out_valid, 1);
    check("flush_pre_addr", out_addr, vecs[1].addr);
    rst = 1'b1;
    @(negedge clk);
    check("flush_out_valid", out_valid, 0);
    check("flush_out_addr", out_addr, 0);
    check("flush_out_tag", out_tag, 0);
    check("flush_in_ready", in_ready, 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    $display("mid-operation reset applied");
    for (int k = 0; k < 6; k++) begin
      #1;
      check("flush_no_stale", out_valid, 0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
